// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// The master drives the operands and start; the slave returns the handshake and the result.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin.
// One full-adder cell and a carry flop handle one bit per clock, LSB first.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int unsigned CW   = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
   localparam int unsigned LAST = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;

   logic             fa_sum;
   logic             fa_carry;
   logic [WIDTH-1:0] res_next;
   logic             last_bit;

   // Single full-adder cell on the current LSBs
   always_comb begin
      fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
      fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      last_bit = (count == CW'(LAST));
   end

   // New sum bit enters at the MSB so the word is aligned after WIDTH shifts
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next = fa_sum;
      end else begin : g_res_wn
         assign res_next = {fa_sum, res_sh[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         carry    <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sh     <= bus.a;
                  b_sh     <= bus.b;
                  carry    <= bus.cin;
                  count    <= '0;
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end

            SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               carry  <= fa_carry;
               count  <= count + CW'(1);
               // Result becomes visible only once the last bit has been produced
               if (last_bit) begin
                  bus.sum  <= res_next;
                  bus.cout <= fa_carry;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end

            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, plus a WIDTH=1 instance
// exercised over all input combinations.
module tb_serial_adder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   serial_adder_if #(.WIDTH(8)) bus8 ();
   serial_adder_if #(.WIDTH(1)) bus1 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus8.busy); end
      checks++;
      if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus8.done); end
      checks++;
      if (bus8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", bus8.sum); end
      checks++;
      if (bus8.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", bus8.cout); end
      checks++;
      if (bus1.done !== 1'b0 || bus1.sum !== 1'b0 || bus1.cout !== 1'b0) begin
         errors++;
         $display("FAIL reset_w1 got done=%b sum=%b cout=%b want 0 0 0", bus1.done, bus1.sum, bus1.cout);
      end
   endtask

   // One full transaction with latency, busy, result and single-pulse checks
   task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] exp_sum, input logic exp_cout, input bit detail);
      int lat;
      bit busy_ok;
      bus8.a     = a;
      bus8.b     = b;
      bus8.cin   = cin;
      bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (bus8.done !== 1'b1 && lat < 20) begin
         if (bus8.busy !== 1'b1) busy_ok = 1'b0;
         step();
         lat++;
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL latency a=%h b=%h cin=%b got %0d want 8", a, b, cin, lat);
      end
      checks++;
      if ({bus8.cout, bus8.sum} !== {exp_cout, exp_sum}) begin
         errors++;
         $display("FAIL result a=%h b=%h cin=%b got %b_%h want %b_%h",
                  a, b, cin, bus8.cout, bus8.sum, exp_cout, exp_sum);
      end
      if (detail) begin
         checks++;
         if (!busy_ok || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_window a=%h b=%h got busy_ok=%b busy_at_done=%b want 1 0",
                     a, b, busy_ok, bus8.busy);
         end
         step();
         checks++;
         if (bus8.done !== 1'b0 || bus8.sum !== exp_sum || bus8.cout !== exp_cout) begin
            errors++;
            $display("FAIL done_pulse_hold got done=%b sum=%h cout=%b want 0 %h %b",
                     bus8.done, bus8.sum, bus8.cout, exp_sum, exp_cout);
         end
      end else begin
         step();
      end
   endtask

   task automatic test_vectors();
      run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
      run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1);
      run_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b1);
   endtask

   task automatic test_start_ignored();
      int pulses;
      int at;
      logic [7:0] got_sum;
      logic       got_cout;
      bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
      step();
      pulses = 0; at = 0; got_sum = 8'h00; got_cout = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         if (i == 2 || i == 5) begin
            bus8.start = 1'b1; bus8.a = 8'hF0 + 8'(i); bus8.b = 8'hEE; bus8.cin = 1'b1;
         end else begin
            bus8.start = 1'b0;
         end
         step();
         if (bus8.done === 1'b1) begin
            pulses++; at = i; got_sum = bus8.sum; got_cout = bus8.cout;
         end
      end
      checks++;
      if (pulses != 1 || at != 8) begin
         errors++;
         $display("FAIL ignore_start_pulses got %0d at %0d want 1 at 8", pulses, at);
      end
      checks++;
      if (got_sum !== 8'h46 || got_cout !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_result got %b_%h want 0_46", got_cout, got_sum);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                  bus8.busy, bus8.done, bus8.sum, bus8.cout);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus8.done === 1'b1 || bus8.busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL mid_reset_quiet got %0d active cycles want 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] op_a  [4] = '{8'h10, 8'h80, 8'h7F, 8'hC8};
      logic [7:0] op_b  [4] = '{8'h20, 8'h80, 8'h01, 8'h64};
      logic       op_c  [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
      logic [7:0] ex_s  [4] = '{8'h30, 8'h01, 8'h80, 8'h2D};
      logic       ex_co [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
      int   k, cyc, last_cyc, unstable;
      bit   pend;
      logic [7:0] held;
      bus8.a = op_a[0]; bus8.b = op_b[0]; bus8.cin = op_c[0]; bus8.start = 1'b1;
      step();
      bus8.a = op_a[1]; bus8.b = op_b[1]; bus8.cin = op_c[1];
      k = 0; cyc = 0; last_cyc = 0; unstable = 0; pend = 1'b0; held = 8'h00;
      while (k < 4 && cyc < 100) begin
         step();
         cyc++;
         if (bus8.done === 1'b1) begin
            checks++;
            if (bus8.sum !== ex_s[k] || bus8.cout !== ex_co[k]) begin
               errors++;
               $display("FAIL b2b_result[%0d] got %b_%h want %b_%h", k, bus8.cout, bus8.sum, ex_co[k], ex_s[k]);
            end
            checks++;
            if (cyc - last_cyc != ((k == 0) ? 8 : 9)) begin
               errors++;
               $display("FAIL b2b_interval[%0d] got %0d want %0d", k, cyc - last_cyc, (k == 0) ? 8 : 9);
            end
            held     = ex_s[k];
            last_cyc = cyc;
            k++;
            if (k >= 4) bus8.start = 1'b0;
            pend = 1'b1;
         end else begin
            if (bus8.sum !== held) unstable++;
            if (pend && k + 1 < 4) begin
               bus8.a = op_a[k+1]; bus8.b = op_b[k+1]; bus8.cin = op_c[k+1];
            end
            pend = 1'b0;
         end
      end
      bus8.start = 1'b0;
      checks++;
      if (k != 4) begin
         errors++;
         $display("FAIL b2b_timeout got %0d results want 4", k);
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL b2b_sum_stable got %0d changes between pulses want 0", unstable);
      end
      step();
   endtask

   task automatic test_width1();
      logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      logic [2:0] v;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0]; bus1.start = 1'b1;
         step();
         bus1.start = 1'b0;
         checks++;
         if (bus1.busy !== 1'b1) begin
            errors++;
            $display("FAIL w1_busy[%0d] got %b want 1", i, bus1.busy);
         end
         step();
         checks++;
         if (bus1.done !== 1'b1 || {bus1.cout, bus1.sum} !== exp_tab[i]) begin
            errors++;
            $display("FAIL w1_result[%0d] got done=%b %b%b want 1 %b", i, bus1.done, bus1.cout, bus1.sum, exp_tab[i]);
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] tot;
      for (int i = 0; i < 1000; i++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rc  = 1'($urandom_range(0, 1));
         tot = 9'(ra) + 9'(rb) + 9'(rc);
         run_add(ra, rb, rc, tot[7:0], tot[8], 1'b0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
      test_reset();
      test_vectors();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_width1();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
